cmp_window_stats: RTL and testbench

Downstream consumer of the 4-bit magnitude comparator's greater/equal/lesser flags. It accumulates per-outcome counts over a fixed window of WINDOW accepted samples and tracks the longest run of consecutive "equal" results. It flags samples whose flags are not one-hot. At each window boundary it emits a summary record over a valid/ready handshake.

---
 rtl/cmp_window_stats.sv | 172 +++++++++++++++++
 tb/tb_cmp_window_stats.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_window_stats.sv
// Windowed statistics over comparator greater/equal/lesser flags.
// Counts outcomes and longest equal run per WINDOW samples and hands each record out over valid/ready.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid          comparator flags valid this cycle
//   greater/equal/    comparator flags for this sample
//   lesser
//   in_ready          high while collecting a window (ACCUM)
//   out_valid         summary record valid (HOLD)
//   out_ready         downstream accepts the record
//   gt_cnt, eq_cnt,   per-outcome counts of the last completed window
//   lt_cnt, err_cnt
//   max_eq_run        longest run of equal-only samples in that window
module cmp_window_stats #(
  parameter int WINDOW = 8,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic          greater,
  input  logic          equal,
  input  logic          lesser,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] gt_cnt,
  output logic [CW-1:0] eq_cnt,
  output logic [CW-1:0] lt_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] max_eq_run
);

  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] idx;
  logic [CW-1:0] gt_acc;
  logic [CW-1:0] eq_acc;
  logic [CW-1:0] lt_acc;
  logic [CW-1:0] err_acc;
  logic [CW-1:0] cur_run;
  logic [CW-1:0] max_run;

  logic [CW-1:0] gt_nxt;
  logic [CW-1:0] eq_nxt;
  logic [CW-1:0] lt_nxt;
  logic [CW-1:0] err_nxt;
  logic [CW-1:0] run_nxt;
  logic [CW-1:0] max_nxt;

  logic take;
  logic last;
  logic is_gt;
  logic is_eq;
  logic is_lt;
  logic is_err;

  // Only the three exact one-hot patterns count as outcomes.
  always_comb begin
    is_gt  = 1'b0;
    is_eq  = 1'b0;
    is_lt  = 1'b0;
    is_err = 1'b0;
    unique case ({greater, equal, lesser})
      3'b100:  is_gt  = 1'b1;
      3'b010:  is_eq  = 1'b1;
      3'b001:  is_lt  = 1'b1;
      default: is_err = 1'b1;
    endcase
  end

  assign take = in_valid && in_ready;
  assign last = (idx == LAST);

  // Window totals including the sample being accepted this cycle.
  always_comb begin
    gt_nxt  = gt_acc  + (is_gt  ? ONE : '0);
    eq_nxt  = eq_acc  + (is_eq  ? ONE : '0);
    lt_nxt  = lt_acc  + (is_lt  ? ONE : '0);
    err_nxt = err_acc + (is_err ? ONE : '0);
    run_nxt = is_eq ? cur_run + ONE : '0;
    max_nxt = (run_nxt > max_run) ? run_nxt : max_run;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (take && last) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulators restart on the closing sample so runs never span windows.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      gt_acc  <= '0;
      eq_acc  <= '0;
      lt_acc  <= '0;
      err_acc <= '0;
      cur_run <= '0;
      max_run <= '0;
    end else if (take) begin
      if (last) begin
        idx     <= '0;
        gt_acc  <= '0;
        eq_acc  <= '0;
        lt_acc  <= '0;
        err_acc <= '0;
        cur_run <= '0;
        max_run <= '0;
      end else begin
        idx     <= idx + ONE;
        gt_acc  <= gt_nxt;
        eq_acc  <= eq_nxt;
        lt_acc  <= lt_nxt;
        err_acc <= err_nxt;
        cur_run <= run_nxt;
        max_run <= max_nxt;
      end
    end
  end

  // Record registers hold their values until the next window closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      gt_cnt     <= '0;
      eq_cnt     <= '0;
      lt_cnt     <= '0;
      err_cnt    <= '0;
      max_eq_run <= '0;
    end else if (take && last) begin
      gt_cnt     <= gt_nxt;
      eq_cnt     <= eq_nxt;
      lt_cnt     <= lt_nxt;
      err_cnt    <= err_nxt;
      max_eq_run <= max_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_window_stats.sv
// Randomized and directed bench for cmp_window_stats.
// Reference model keeps each window as a list of flag patterns.
module tb_cmp_window_stats;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          greater;
  logic          equal;
  logic          lesser;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] gt_cnt;
  logic [CW-1:0] eq_cnt;
  logic [CW-1:0] lt_cnt;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] max_eq_run;

  cmp_window_stats #(.WINDOW(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .greater(greater),
    .equal(equal),
    .lesser(lesser),
    .in_ready(in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gt_cnt(gt_cnt),
    .eq_cnt(eq_cnt),
    .lt_cnt(lt_cnt),
    .err_cnt(err_cnt),
    .max_eq_run(max_eq_run)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  bit         m_hold = 1'b0;
  logic [2:0] win[$];
  int e_gt  = 0;
  int e_eq  = 0;
  int e_lt  = 0;
  int e_err = 0;
  int e_run = 0;

  task automatic check(string tag, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Summarise a completed window from its list of samples.
  task automatic close_window();
    int run;
    e_gt = 0; e_eq = 0; e_lt = 0; e_err = 0; e_run = 0;
    run = 0;
    foreach (win[i]) begin
      case (win[i])
        3'b100:  e_gt++;
        3'b010:  e_eq++;
        3'b001:  e_lt++;
        default: e_err++;
      endcase
      if (win[i] == 3'b010) begin
        run++;
        if (run > e_run) e_run = run;
      end else begin
        run = 0;
      end
    end
    win.delete();
  endtask

  task automatic cycle(bit rst, bit v, logic [2:0] f, bit ordy);
    bit was_hold;
    reset     = rst;
    in_valid  = v;
    {greater, equal, lesser} = f;
    out_ready = ordy;
    @(posedge clk);
    was_hold = m_hold;
    if (rst) begin
      win.delete();
      m_hold = 0;
      e_gt = 0; e_eq = 0; e_lt = 0; e_err = 0; e_run = 0;
    end else if (!m_hold) begin
      if (v) begin
        win.push_back(f);
        if (win.size() == W) begin
          close_window();
          m_hold = 1;
        end
      end
    end else if (ordy) begin
      m_hold = 0;
    end
    #1;
    check("out_valid", int'(out_valid), int'(m_hold));
    check("in_ready", int'(in_ready), int'(!m_hold));
    check("gt_cnt", int'(gt_cnt), e_gt);
    check("eq_cnt", int'(eq_cnt), e_eq);
    check("lt_cnt", int'(lt_cnt), e_lt);
    check("err_cnt", int'(err_cnt), e_err);
    check("max_eq_run", int'(max_eq_run), e_run);
    if (out_valid && !was_hold && !rst) begin
      check("sum_window",
            int'(gt_cnt) + int'(eq_cnt) + int'(lt_cnt) + int'(err_cnt), W);
    end
  endtask

  // Finish any pending record, then present one accepted sample.
  task automatic sample(logic [2:0] f);
    while (m_hold) cycle(0, 0, 3'b000, 1);
    cycle(0, 1, f, 0);
  endtask

  logic [2:0] tp1[8];

  initial begin
    tp1 = '{3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010, 3'b100};

    cycle(1, 0, 3'b000, 0);
    cycle(1, 0, 3'b000, 0);
    check("reset_valid", int'(out_valid), 0);
    check("reset_ready", int'(in_ready), 1);
    check("reset_gt", int'(gt_cnt), 0);

    for (int i = 0; i < 8; i++) cycle(0, 1, tp1[i], 0);
    check("tp1_valid", int'(out_valid), 1);
    check("tp1_gt", int'(gt_cnt), 3);
    check("tp1_eq", int'(eq_cnt), 4);
    check("tp1_lt", int'(lt_cnt), 1);
    check("tp1_err", int'(err_cnt), 0);
    check("tp1_run", int'(max_eq_run), 3);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 3'b001, 0);
      check("hold_ready", int'(in_ready), 0);
      check("hold_gt", int'(gt_cnt), 3);
    end
    cycle(0, 1, 3'b001, 1);
    check("release_valid", int'(out_valid), 0);
    check("release_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) sample(3'b000);
    check("zero_err", int'(err_cnt), 8);
    check("zero_run", int'(max_eq_run), 0);
    sample(3'b110);
    for (int i = 0; i < 7; i++) sample(3'b100);
    check("one_err", int'(err_cnt), 1);
    check("one_err_gt", int'(gt_cnt), 7);

    sample(3'b100); sample(3'b001); sample(3'b100); sample(3'b001);
    for (int i = 0; i < 4; i++) sample(3'b010);
    check("tail_run", int'(max_eq_run), 4);
    sample(3'b010); sample(3'b010);
    for (int i = 0; i < 6; i++) sample(3'b001);
    check("no_carry", int'(max_eq_run), 2);

    for (int i = 0; i < 8; i++) begin
      sample(3'b010);
      cycle(0, 0, 3'($urandom), 0);
    end
    check("gap_eq", int'(eq_cnt), 8);
    check("gap_run", int'(max_eq_run), 8);

    for (int i = 0; i < 5; i++) sample(3'b100);
    cycle(1, 1, 3'b100, 0);
    for (int i = 0; i < 8; i++) sample(3'b001);
    check("post_rst_lt", int'(lt_cnt), 8);
    check("post_rst_gt", int'(gt_cnt), 0);
    cycle(1, 0, 3'b000, 0);
    check("hold_rst_valid", int'(out_valid), 0);

    for (int n = 0; n < 4000; n++) begin
      logic [2:0] f;
      if ($urandom_range(0, 9) < 7) begin
        f = 3'b001 << $urandom_range(0, 2);
      end else begin
        f = 3'($urandom);
      end
      if ($urandom_range(0, 4) == 0 && f != 3'b010) f = 3'b010;
      cycle($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0,
            f, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
